// File: rtl/bsg_two_fifo_width_p9.sv
// Two-entry ready/valid to valid/yumi FIFO feeding the width-9 register stage.
// Registered ready_o and v_o, with no bypass from data_i to data_o.
module bsg_two_fifo_width_p9 #(
  parameter int width_p = 9
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i,
  output logic               error_o
);

  logic [1:0][width_p-1:0] r_mem;
  logic                    r_wptr;
  logic                    r_rptr;
  logic                    r_empty;
  logic                    r_full;
  logic                    r_error;
  logic                    w_enq;
  logic                    w_deq;

  assign ready_o = reset_n_i & ~r_full;
  assign v_o     = ~r_empty;
  assign data_o  = r_mem[r_rptr];
  assign error_o = r_error;

  assign w_enq = valid_i & ready_o;
  assign w_deq = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_mem   <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= ~r_wptr;
      end
      if (w_deq)
        r_rptr <= ~r_rptr;
      if (yumi_i && r_empty)
        r_error <= 1'b1;
      // Enq implies not full, so ~empty means occupancy was exactly 1.
      if (w_enq && !w_deq) begin
        r_empty <= 1'b0;
        r_full  <= ~r_empty;
      end else if (w_deq && !w_enq) begin
        r_full  <= 1'b0;
        r_empty <= ~r_full;
      end
    end
  end

endmodule

// File: tb/tb_bsg_two_fifo_width_p9.sv
// Bench for bsg_two_fifo_width_p9: directed vector table, then streaming and
// random traffic checked against a queue-based reference model.
module tb_bsg_two_fifo_width_p9;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic [8:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [8:0] data_o;
  logic       v_o;
  logic       yumi_i;
  logic       error_o;

  int n_vec = 0;
  int n_bad = 0;

  bsg_two_fifo_width_p9 #(.width_p(9)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .error_o  (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [8:0] din;
    logic       yumi;
    logic       ready;
    logic       v;
    logic       chk_d;
    logic [8:0] dout;
    logic       err;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic valid, logic [8:0] din, logic yumi,
                              logic ready, logic v, logic chk_d, logic [8:0] dout,
                              logic err);
    vec_t t;
    t.rst_n = rst_n; t.valid = valid; t.din = din; t.yumi = yumi;
    t.ready = ready; t.v = v; t.chk_d = chk_d; t.dout = dout; t.err = err;
    return t;
  endfunction

  vec_t tbl[24];

  // Reference model: a plain queue of buffered words plus a sticky error bit.
  logic [8:0] q[$];
  logic       m_err;

  task automatic model_step(input logic rst_n, input logic valid, input logic [8:0] din,
                            input logic yumi, input string tag);
    logic       e_ready, e_v;
    logic [8:0] head;
    int         sz;
    reset_n_i = rst_n; valid_i = valid; data_i = din; yumi_i = yumi;
    @(negedge clk_i);
    sz      = q.size();
    e_ready = rst_n && (sz < 2);
    e_v     = (sz > 0);
    head    = e_v ? q[0] : 9'h000;
    n_vec++;
    if (ready_o !== e_ready || v_o !== e_v || error_o !== m_err ||
        (e_v && data_o !== head) || sz > 2) begin
      n_bad++;
      $display("FAIL %s: ready=%b v=%b data=%h err=%b, want ready=%b v=%b data=%h err=%b",
               tag, ready_o, v_o, data_o, error_o, e_ready, e_v, head, m_err);
    end
    @(posedge clk_i);
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (yumi && sz == 0) m_err = 1'b1;
      if (yumi && sz > 0) void'(q.pop_front());
      if (valid && sz < 2) q.push_back(din);
    end
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 9'h1AA, 0,  0, 0, 1, 9'h000, 0);
    tbl[1]  = mk(0, 1, 9'h1AA, 0,  0, 0, 1, 9'h000, 0);
    tbl[2]  = mk(1, 1, 9'h055, 0,  1, 0, 1, 9'h000, 0);
    tbl[3]  = mk(1, 0, 9'h000, 1,  1, 1, 1, 9'h055, 0);
    tbl[4]  = mk(1, 0, 9'h000, 0,  1, 0, 0, 9'h000, 0);
    tbl[5]  = mk(1, 1, 9'h101, 0,  1, 0, 0, 9'h000, 0);
    tbl[6]  = mk(1, 1, 9'h0FE, 0,  1, 1, 1, 9'h101, 0);
    tbl[7]  = mk(1, 1, 9'h1FF, 0,  0, 1, 1, 9'h101, 0);
    tbl[8]  = mk(1, 0, 9'h000, 1,  0, 1, 1, 9'h101, 0);
    tbl[9]  = mk(1, 0, 9'h000, 0,  1, 1, 1, 9'h0FE, 0);
    tbl[10] = mk(1, 0, 9'h000, 1,  1, 1, 1, 9'h0FE, 0);
    tbl[11] = mk(1, 0, 9'h000, 0,  1, 0, 0, 9'h000, 0);
    tbl[12] = mk(1, 0, 9'h000, 1,  1, 0, 0, 9'h000, 0);
    tbl[13] = mk(1, 1, 9'h0AB, 0,  1, 0, 0, 9'h000, 1);
    tbl[14] = mk(1, 0, 9'h000, 1,  1, 1, 1, 9'h0AB, 1);
    tbl[15] = mk(1, 0, 9'h000, 0,  1, 0, 0, 9'h000, 1);
    tbl[16] = mk(0, 0, 9'h000, 0,  0, 0, 0, 9'h000, 1);
    tbl[17] = mk(1, 0, 9'h000, 0,  1, 0, 1, 9'h000, 0);
    tbl[18] = mk(1, 1, 9'h003, 0,  1, 0, 1, 9'h000, 0);
    tbl[19] = mk(1, 1, 9'h004, 0,  1, 1, 1, 9'h003, 0);
    tbl[20] = mk(0, 0, 9'h000, 0,  0, 1, 1, 9'h003, 0);
    tbl[21] = mk(1, 1, 9'h007, 0,  1, 0, 1, 9'h000, 0);
    tbl[22] = mk(1, 0, 9'h000, 1,  1, 1, 1, 9'h007, 0);
    tbl[23] = mk(1, 0, 9'h000, 0,  1, 0, 0, 9'h000, 0);

    reset_n_i = 1'b0; valid_i = 1'b0; data_i = '0; yumi_i = 1'b0;
    @(posedge clk_i); #1;

    // Each record: inputs held for one cycle, outputs expected in that cycle.
    for (int i = 0; i < 24; i++) begin
      reset_n_i = tbl[i].rst_n; valid_i = tbl[i].valid;
      data_i = tbl[i].din; yumi_i = tbl[i].yumi;
      @(negedge clk_i);
      n_vec++;
      if (ready_o !== tbl[i].ready || v_o !== tbl[i].v || error_o !== tbl[i].err ||
          (tbl[i].chk_d && data_o !== tbl[i].dout)) begin
        n_bad++;
        $display("FAIL vec%0d: ready=%b v=%b data=%h err=%b, want ready=%b v=%b data=%h err=%b",
                 i, ready_o, v_o, data_o, error_o, tbl[i].ready, tbl[i].v, tbl[i].dout,
                 tbl[i].err);
      end
      @(posedge clk_i); #1;
    end

    q.delete(); m_err = 1'b0;
    model_step(0, 0, 9'h000, 0, "rst");
    model_step(0, 1'bx, 9'hxxx, 0, "rst_x");

    // Streaming: consumer takes the head whenever the model says one exists.
    for (int i = 0; i <= 20; i++)
      model_step(1, 1, i[8:0], q.size() > 0, "stream");
    while (q.size() > 0)
      model_step(1, 0, 9'h000, 1, "drain");

    for (int i = 0; i < 200; i++)
      model_step(1, 1'($urandom_range(0, 1)), 9'($urandom),
                 (q.size() > 0) && 1'($urandom_range(0, 1)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
